pmem_arbiter: RTL and testbench

PMEM_ARBITER -- requirements
Module: pmem_arbiter

---
 rtl/pmem_arbiter_pkg.sv | 25 ++
 rtl/pmem_arbiter_if.sv | 47 ++++
 rtl/pmem_arbiter_watchdog.sv | 41 ++++
 rtl/pmem_arbiter.sv | 113 +++++++++++
 tb/tb_pmem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D-cache physical memory arbiter.
// Holds the FSM state encoding, the port identifiers and the cache line type.
package lc3b_types;

    localparam int LC3B_LINE_WIDTH = 128;

    typedef logic [LC3B_LINE_WIDTH-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_I  = 2'd1,
        BUSY_D  = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } arb_port_t;

    function automatic logic arb_is_busy(arb_state_t s);
        return (s == BUSY_I) || (s == BUSY_D);
    endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of cache-side, memory-side and status signals around the arbiter.
// slave is the arbiter's view; master is the caches' and memory's view.
interface pmem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  pmem_read_i;
    logic                  pmem_write_i;
    logic [ADDR_WIDTH-1:0] pmem_address_i;
    logic [LINE_WIDTH-1:0] pmem_wdata_i;
    logic                  pmem_read_d;
    logic                  pmem_write_d;
    logic [ADDR_WIDTH-1:0] pmem_address_d;
    logic [LINE_WIDTH-1:0] pmem_wdata_d;
    logic                  pmem_resp_i;
    logic                  pmem_resp_d;
    logic [LINE_WIDTH-1:0] pmem_rdata_i;
    logic [LINE_WIDTH-1:0] pmem_rdata_d;
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic                  pmem_resp;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  grant_i;
    logic                  grant_d;
    logic                  timeout_err;

    modport slave (
        input  pmem_read_i, pmem_write_i, pmem_address_i, pmem_wdata_i,
        input  pmem_read_d, pmem_write_d, pmem_address_d, pmem_wdata_d,
        input  pmem_resp, pmem_rdata,
        output pmem_resp_i, pmem_resp_d, pmem_rdata_i, pmem_rdata_d,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        output grant_i, grant_d, timeout_err
    );

    modport master (
        output pmem_read_i, pmem_write_i, pmem_address_i, pmem_wdata_i,
        output pmem_read_d, pmem_write_d, pmem_address_d, pmem_wdata_d,
        output pmem_resp, pmem_rdata,
        input  pmem_resp_i, pmem_resp_d, pmem_rdata_i, pmem_rdata_d,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  grant_i, grant_d, timeout_err
    );

endinterface

// File: rtl/pmem_arbiter_watchdog.sv
// Busy-cycle watchdog: counts cycles of an outstanding memory request and
// raises a sticky error once the count saturates at TIMEOUT.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_busy,
    input  logic i_resp,
    output logic o_timeout_err
);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_tick;

    assign w_tick        = i_busy & ~i_resp & (r_cnt != LP_LIMIT);
    assign o_timeout_err = r_err;

    // The error is set on the edge where the count reaches the limit; the
    // arbiter itself keeps waiting, only reset clears the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_tick && (r_cnt == LP_LIMIT - 1'b1)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter in front of a single physical memory.
// One transaction at a time, alternating priority on ties, one idle cycle after each response.
module pmem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    pmem_arbiter_if.slave  bus
);
    arb_state_t            r_state;
    arb_state_t            w_state_next;
    arb_port_t             r_last_grant;
    arb_port_t             w_last_grant_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [LINE_WIDTH-1:0] r_wdata;
    logic [LINE_WIDTH-1:0] w_wdata_next;
    logic                  r_op_write;
    logic                  w_op_write_next;
    logic                  w_req_i;
    logic                  w_req_d;
    logic                  w_grant_start;
    logic                  w_busy;
    logic                  w_resp_i;
    logic                  w_resp_d;

    assign w_req_i = bus.pmem_read_i | bus.pmem_write_i;
    assign w_req_d = bus.pmem_read_d | bus.pmem_write_d;
    assign w_busy  = arb_is_busy(r_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op_write   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
            r_op_write   <= w_op_write_next;
        end
    end

    // Write wins over read when a port raises both strobes.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        w_op_write_next   = r_op_write;
        w_grant_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_d && (!w_req_i || (r_last_grant == PORT_I))) begin
                    w_state_next      = BUSY_D;
                    w_last_grant_next = PORT_D;
                    w_addr_next       = bus.pmem_address_d;
                    w_wdata_next      = bus.pmem_wdata_d;
                    w_op_write_next   = bus.pmem_write_d;
                    w_grant_start     = 1'b1;
                end else if (w_req_i) begin
                    w_state_next      = BUSY_I;
                    w_last_grant_next = PORT_I;
                    w_addr_next       = bus.pmem_address_i;
                    w_wdata_next      = bus.pmem_wdata_i;
                    w_op_write_next   = bus.pmem_write_i;
                    w_grant_start     = 1'b1;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.pmem_resp) begin
                    w_state_next = RECOVER;
                end
            end
            RECOVER: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.pmem_read    = w_busy & ~r_op_write;
    assign bus.pmem_write   = w_busy & r_op_write;
    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = r_wdata;
    assign bus.grant_i      = (r_state == BUSY_I);
    assign bus.grant_d      = (r_state == BUSY_D);

    // Response is passed straight through to the owning port in the same cycle.
    assign w_resp_i         = bus.grant_i & bus.pmem_resp;
    assign w_resp_d         = bus.grant_d & bus.pmem_resp;
    assign bus.pmem_resp_i  = w_resp_i;
    assign bus.pmem_resp_d  = w_resp_d;
    assign bus.pmem_rdata_i = w_resp_i ? bus.pmem_rdata : '0;
    assign bus.pmem_rdata_d = w_resp_d ? bus.pmem_rdata : '0;

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_grant_start),
        .i_busy        (w_busy),
        .i_resp        (bus.pmem_resp),
        .o_timeout_err (bus.timeout_err)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed and randomized checks of pmem_arbiter against a transaction-level
// model of the caches and memory (tie alternation, latched requests, data routing).
module tb_pmem_arbiter;
    import lc3b_types::*;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chkv(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memory model: answers after mem_lat extra busy cycles with a line derived from the address.
    bit       mem_en   = 1'b1;
    bit       mem_rand = 1'b0;
    int       mem_lat  = 1;
    int       mem_cnt  = 0;
    lc3b_line mem_pat  = '0;

    function automatic lc3b_line mem_data(input logic [AW-1:0] a);
        return (mem_pat != '0) ? mem_pat : {8{~a}};
    endfunction

    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = '0;
            if (mem_en && (bus.pmem_read || bus.pmem_write)) begin
                mem_cnt++;
                if (mem_cnt == 1 && mem_rand) mem_lat = $urandom_range(0, 5);
                if (mem_cnt == mem_lat + 1) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = mem_data(bus.pmem_address);
                end
            end else begin
                mem_cnt = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, observed %0d compared", n_cmp);
        $fatal(1, "time limit");
    end

    // Recorded history for the directed steps.
    int         c_read, c_write, c_resp_i, c_resp_d, c_post_gnt;
    int         dcnt_i = -1;
    int         dcnt_d = -1;
    lc3b_line   lat_rdata_i, lat_rdata_d;
    bit         prev_gi, prev_gd, prev_resp;
    bit         g_port[$];
    bit         g_wr[$];
    logic [AW-1:0] g_addr[$];
    lc3b_line   g_wd[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_i(input logic rd, input logic wr, input logic [AW-1:0] a, input lc3b_line wd);
        bus.pmem_read_i = rd; bus.pmem_write_i = wr; bus.pmem_address_i = a; bus.pmem_wdata_i = wd;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [AW-1:0] a, input lc3b_line wd);
        bus.pmem_read_d = rd; bus.pmem_write_d = wr; bus.pmem_address_d = a; bus.pmem_wdata_d = wd;
    endtask

    task automatic drive_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a, input lc3b_line wd);
        if (p == 0) drive_i(rd, wr, a, wd);
        else        drive_d(rd, wr, a, wd);
    endtask

    task automatic clear_rec();
        c_read = 0; c_write = 0; c_resp_i = 0; c_resp_d = 0; c_post_gnt = 0;
        lat_rdata_i = '0; lat_rdata_d = '0;
        prev_gi = 1'b0; prev_gd = 1'b0; prev_resp = 1'b0;
        g_port.delete(); g_wr.delete(); g_addr.delete(); g_wd.delete();
    endtask

    task automatic do_reset(input bit en, input int lat, input lc3b_line pat);
        @(negedge clk);
        rst_n = 1'b0;
        drive_i(1'b0, 1'b0, '0, '0);
        drive_d(1'b0, 1'b0, '0, '0);
        mem_en = en; mem_lat = lat; mem_pat = pat; mem_rand = 1'b0;
        dcnt_i = -1; dcnt_d = -1;
        @(negedge clk);
        step();
        rst_n = 1'b1;
        clear_rec();
    endtask

    // hold: cycles a port keeps its request after its response (-1 = forever).
    task automatic run(input int n, input int hold);
        for (int c = 0; c < n; c++) begin
            step();
            if (dcnt_i == 0) begin drive_i(1'b0, 1'b0, '0, '0); dcnt_i = -1; end
            else if (dcnt_i > 0) dcnt_i--;
            if (dcnt_d == 0) begin drive_d(1'b0, 1'b0, '0, '0); dcnt_d = -1; end
            else if (dcnt_d > 0) dcnt_d--;
            @(negedge clk);
            if (bus.pmem_read)  c_read++;
            if (bus.pmem_write) c_write++;
            if (prev_resp && (bus.grant_i || bus.grant_d)) c_post_gnt++;
            if (bus.grant_i && !prev_gi) begin
                g_port.push_back(1'b0); g_wr.push_back(bus.pmem_write);
                g_addr.push_back(bus.pmem_address); g_wd.push_back(bus.pmem_wdata);
            end
            if (bus.grant_d && !prev_gd) begin
                g_port.push_back(1'b1); g_wr.push_back(bus.pmem_write);
                g_addr.push_back(bus.pmem_address); g_wd.push_back(bus.pmem_wdata);
            end
            if (bus.pmem_resp_i) begin c_resp_i++; lat_rdata_i = bus.pmem_rdata_i; if (hold >= 0) dcnt_i = hold; end
            if (bus.pmem_resp_d) begin c_resp_d++; lat_rdata_d = bus.pmem_rdata_d; if (hold >= 0) dcnt_d = hold; end
            prev_gi   = bus.grant_i;
            prev_gd   = bus.grant_d;
            prev_resp = bus.pmem_resp_i | bus.pmem_resp_d;
        end
    endtask

    // Random-phase model state, indexed 0 = I port, 1 = D port.
    bit            pend[2], drop[2], ppend[2], pg[2];
    int            eop[2], waitc[2], served[2];
    logic [AW-1:0] ea[2];
    bit            ew[2];
    lc3b_line      ewd[2];
    int            mlast;
    int            exp_p;
    lc3b_line      wd_a;

    initial begin
        drive_i(1'b0, 1'b0, '0, '0);
        drive_d(1'b0, 1'b0, '0, '0);
        clear_rec();

        // Reset state
        repeat (2) @(negedge clk);
        chkb("rst_read", bus.pmem_read, 1'b0);
        chkb("rst_write", bus.pmem_write, 1'b0);
        chkb("rst_grant_i", bus.grant_i, 1'b0);
        chkb("rst_grant_d", bus.grant_d, 1'b0);
        chkb("rst_resp_i", bus.pmem_resp_i, 1'b0);
        chkb("rst_resp_d", bus.pmem_resp_d, 1'b0);
        chkb("rst_timeout", bus.timeout_err, 1'b0);
        chkv("rst_address", LW'(bus.pmem_address), '0);

        // Single I read, 3-cycle memory latency
        do_reset(1'b1, 3, {16{8'hA5}});
        step();
        drive_i(1'b1, 1'b0, 16'h1230, '0);
        @(negedge clk);
        chkb("lat_idle_read", bus.pmem_read, 1'b0);
        run(1, 0);
        chkb("lat_next_read", bus.pmem_read, 1'b1);
        run(10, 0);
        chki("single_read_cycles", c_read, 4);
        chki("single_write_cycles", c_write, 0);
        chki("single_resp_i", c_resp_i, 1);
        chki("single_resp_d", c_resp_d, 0);
        chkv("single_rdata_i", lat_rdata_i, {16{8'hA5}});
        chkv("single_addr", LW'(g_addr[0]), LW'(16'h1230));

        // Simultaneous I read and D write after reset: D first
        wd_a = {4{32'hDEAD_BEEF}};
        do_reset(1'b1, 1, '0);
        step();
        drive_i(1'b1, 1'b0, 16'h0040, '0);
        drive_d(1'b0, 1'b1, 16'h2000, wd_a);
        run(20, 0);
        chki("tie_count", g_port.size(), 2);
        chkb("tie_first_d", g_port[0], 1'b1);
        chkb("tie_first_wr", g_wr[0], 1'b1);
        chkv("tie_first_addr", LW'(g_addr[0]), LW'(16'h2000));
        chkv("tie_first_wdata", g_wd[0], wd_a);
        chkb("tie_second_i", g_port[1], 1'b0);
        chkb("tie_second_rd", g_wr[1], 1'b0);
        chkv("tie_second_addr", LW'(g_addr[1]), LW'(16'h0040));
        chkv("tie_rdata_i", lat_rdata_i, {8{~16'h0040}});
        chki("tie_post_resp_gap", c_post_gnt, 0);

        // Both ports requesting continuously: grants alternate
        do_reset(1'b1, 1, '0);
        step();
        drive_i(1'b1, 1'b0, 16'h0100, '0);
        drive_d(1'b1, 1'b0, 16'h0200, '0);
        run(24, -1);
        chkb("alt_enough", g_port.size() >= 4, 1'b1);
        chkb("alt_0_d", g_port[0], 1'b1);
        chkb("alt_1_i", g_port[1], 1'b0);
        chkb("alt_2_d", g_port[2], 1'b1);
        chkb("alt_3_i", g_port[3], 1'b0);
        chki("alt_post_resp_gap", c_post_gnt, 0);

        // D request held one cycle past its response: one transaction only
        do_reset(1'b1, 1, '0);
        step();
        drive_d(1'b1, 1'b0, 16'h0300, '0);
        run(15, 1);
        chki("stale_count", g_port.size(), 1);
        chki("stale_resp_d", c_resp_d, 1);
        chki("stale_post_resp_gap", c_post_gnt, 0);

        // Reset in the middle of a D write
        do_reset(1'b1, 5, '0);
        step();
        drive_d(1'b0, 1'b1, 16'h0400, {4{32'h1234_5678}});
        for (int k = 0; k < 10 && !bus.pmem_write; k++) @(negedge clk);
        chkb("midrst_pre_write", bus.pmem_write, 1'b1);
        #2;
        rst_n = 1'b0;
        drive_d(1'b0, 1'b0, '0, '0);
        #1;
        chkb("midrst_write", bus.pmem_write, 1'b0);
        chkb("midrst_grant_d", bus.grant_d, 1'b0);
        chkv("midrst_wdata", bus.pmem_wdata, '0);
        step();
        rst_n = 1'b1;
        clear_rec();
        mem_lat = 2;
        step();
        drive_i(1'b1, 1'b0, 16'h0500, '0);
        run(15, 0);
        chki("midrst_after_count", g_port.size(), 1);
        chkb("midrst_after_port", g_port[0], 1'b0);
        chki("midrst_after_resp", c_resp_i, 1);
        chkv("midrst_after_rdata", lat_rdata_i, {8{~16'h0500}});

        // Randomized traffic against the transaction model
        do_reset(1'b1, 1, '0);
        mem_rand = 1'b1;
        mlast = 0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; drop[p] = 0; ppend[p] = 0; pg[p] = 0; waitc[p] = 0; served[p] = 0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (drop[p]) begin
                    pend[p] = 0; drop[p] = 0;
                    drive_port(p, 1'b0, 1'b0, '0, '0);
                end else if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p] = 1;
                    eop[p]  = $urandom_range(0, 2);
                    ea[p]   = AW'($urandom);
                    ew[p]   = (eop[p] != 0);
                    ewd[p]  = {$urandom, $urandom, $urandom, $urandom};
                    drive_port(p, eop[p] != 1, eop[p] != 0, ea[p], ewd[p]);
                end else if (pend[p] && pg[p] && $urandom_range(0, 1) == 1) begin
                    drive_port(p, eop[p] != 1, eop[p] != 0, AW'($urandom), {$urandom, $urandom, $urandom, $urandom});
                end
            end
            @(negedge clk);
            chkb("rnd_gnt_excl", bus.grant_i & bus.grant_d, 1'b0);
            chkb("rnd_req_iff_gnt", bus.pmem_read | bus.pmem_write, bus.grant_i | bus.grant_d);
            chkb("rnd_rd_wr_excl", bus.pmem_read & bus.pmem_write, 1'b0);
            for (int p = 0; p < 2; p++) begin
                logic     g, rsp;
                lc3b_line rd;
                g   = (p == 1) ? bus.grant_d : bus.grant_i;
                rsp = (p == 1) ? bus.pmem_resp_d : bus.pmem_resp_i;
                rd  = (p == 1) ? bus.pmem_rdata_d : bus.pmem_rdata_i;
                if (g && !pg[p]) begin
                    exp_p = (ppend[0] && ppend[1]) ? 1 - mlast : (ppend[1] ? 1 : 0);
                    chkb("rnd_gnt_had_req", ppend[p], 1'b1);
                    chki("rnd_winner", p, exp_p);
                    chkb("rnd_op", bus.pmem_write, ew[p]);
                    if (ew[p]) chkv("rnd_wdata", bus.pmem_wdata, ewd[p]);
                    mlast    = p;
                    waitc[p] = 0;
                end
                if (g) chkv("rnd_hold_addr", LW'(bus.pmem_address), LW'(ea[p]));
                chkb("rnd_resp", rsp, g & bus.pmem_resp);
                chkv("rnd_rdata", rd, (g && bus.pmem_resp) ? {8{~ea[p]}} : '0);
                if (rsp && g) begin drop[p] = 1; served[p]++; end
                if (pend[p] && !g) waitc[p]++;
                if (waitc[p] > 30) begin
                    chki("rnd_starve", waitc[p], 30);
                    waitc[p] = 0;
                end
                pg[p] = g;
            end
            ppend[0] = pend[0];
            ppend[1] = pend[1];
        end
        chkb("rnd_served_i", served[0] > 0, 1'b1);
        chkb("rnd_served_d", served[1] > 0, 1'b1);
        chkb("rnd_no_timeout", bus.timeout_err, 1'b0);

        // Watchdog with TIMEOUT=8 and a silent memory
        do_reset(1'b0, 0, '0);
        step();
        drive_i(1'b1, 1'b0, 16'h0600, '0);
        @(negedge clk);
        for (int b = 1; b <= 12; b++) begin
            @(negedge clk);
            if (b == 8) chkb("wd_before_limit", bus.timeout_err, 1'b0);
            if (b == 9) chkb("wd_at_limit", bus.timeout_err, 1'b1);
        end
        chkb("wd_still_granted", bus.grant_i, 1'b1);
        chkb("wd_still_reading", bus.pmem_read, 1'b1);
        clear_rec();
        prev_gi = 1'b1;
        mem_lat = 0;
        mem_en  = 1'b1;
        run(6, 0);
        chki("wd_late_resp", c_resp_i, 1);
        chkv("wd_late_rdata", lat_rdata_i, {8{~16'h0600}});
        chkb("wd_sticky", bus.timeout_err, 1'b1);
        do_reset(1'b1, 1, '0);
        @(negedge clk);
        chkb("wd_cleared_by_reset", bus.timeout_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
